// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared riscv32i constants and fetch types
package riscv_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP    = 32'h0000_0013;
  localparam logic [XLEN-1:0]    PC_INC = 32'd4;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_t;

  // Redirect targets are word-aligned by dropping the low bits.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - riscv32i fetch stage: owns the PC, drives a 1-cycle imem,
// holds a returned word across stalls and squashes wrong-path fetches on redirect.
module if_fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            stall,
  input  logic                            redirect,
  input  logic [XLEN-1:0]                 redirect_pc,
  output logic [XLEN-1:0]                 imem_addr,
  output logic                            imem_rd_en,
  input  logic [riscv_pkg::INSTR_W-1:0]   imem_rdata,
  output logic [riscv_pkg::INSTR_W-1:0]   if_instr,
  output logic [XLEN-1:0]                 if_pc,
  output logic                            if_valid
);

  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   resp_pc;
  logic              resp_valid;
  logic              hold_valid;
  riscv_pkg::fetch_t hold;
  logic              issue;
  logic              capture;

  assign issue      = ~rst & ~stall & ~redirect;
  assign capture    = ~rst & ~redirect & stall & resp_valid & ~hold_valid;
  assign imem_addr  = fetch_pc;
  assign imem_rd_en = issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      resp_valid <= 1'b0;
      hold_valid <= 1'b0;
    end else if (redirect) begin
      fetch_pc   <= riscv_pkg::align_pc(redirect_pc);
      resp_valid <= 1'b0;
      hold_valid <= 1'b0;
    end else if (stall) begin
      resp_valid <= 1'b0;
      if (capture) hold_valid <= 1'b1;
    end else begin
      // The held word (if any) is consumed this cycle while the next PC issues.
      fetch_pc   <= fetch_pc + riscv_pkg::PC_INC;
      resp_valid <= 1'b1;
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) resp_pc <= fetch_pc;
    if (capture) begin
      hold.instr <= imem_rdata;
      hold.pc    <= resp_pc;
    end
  end

  always_comb begin
    if_instr = riscv_pkg::NOP;
    if_pc    = '0;
    if_valid = 1'b0;
    if (!rst && !redirect) begin
      if (hold_valid) begin
        if_instr = hold.instr;
        if_pc    = hold.pc;
        if_valid = 1'b1;
      end else if (resp_valid) begin
        if_instr = imem_rdata;
        if_pc    = resp_pc;
        if_valid = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - scoreboard bench for if_fetch_stage with a program-order model
module tb_if_fetch_stage;

  localparam logic [31:0] KEY   = 32'hA5A5_0000;
  localparam logic [31:0] NOP_W = 32'h0000_0013;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr, imem_rdata, if_instr, if_pc;
  logic        imem_rd_en, if_valid;

  logic [31:0] w_addr, w_instr, w_pc;
  logic        w_rd_en, w_valid;

  if_fetch_stage #(.XLEN(32), .RESET_PC(RPC)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .imem_rdata(imem_rdata),
    .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid)
  );

  if_fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
    .imem_addr(w_addr), .imem_rd_en(w_rd_en), .imem_rdata(32'h0),
    .if_instr(w_instr), .if_pc(w_pc), .if_valid(w_valid)
  );

  // Synchronous-read memory; junk on idle cycles so stale data is never trusted.
  always @(posedge clk) imem_rdata <= imem_rd_en ? (imem_addr ^ KEY) : $urandom;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_pc = RPC;
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the oldest unconsumed fetch in program order must be on the outputs.
  always @(negedge clk) begin
    chk("imem_rd_en", {31'b0, imem_rd_en}, {31'b0, ~rst & ~stall & ~redirect});
    if (!rst) chk("imem_addr", imem_addr, m_pc);
    if (rst || redirect || sb.size() == 0) begin
      chk("idle_valid", {31'b0, if_valid}, 32'd0);
      chk("idle_instr", if_instr, NOP_W);
      chk("idle_pc", if_pc, 32'd0);
    end else begin
      chk("out_valid", {31'b0, if_valid}, 32'd1);
      chk("out_pc", if_pc, sb[0].pc);
      chk("out_instr", if_instr, sb[0].instr);
      if (!stall) void'(sb.pop_front());
    end
  end

  task automatic cyc(input logic r, input logic s, input logic d, input logic [31:0] tpc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; stall = s; redirect = d; redirect_pc = tpc;
    @(negedge clk);
    #2;
    if (r) begin
      sb.delete();
      m_pc = RPC;
    end else if (d) begin
      sb.delete();
      m_pc = {tpc[31:2], 2'b00};
    end else if (!s) begin
      e.pc = m_pc;
      e.instr = m_pc ^ KEY;
      sb.push_back(e);
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic run(input int n, input logic s);
    for (int i = 0; i < n; i++) cyc(1'b0, s, 1'b0, 32'h0);
  endtask

  // Wrap-around instance: RESET_PC=FFFF_FFFC must fetch FFFF_FFFC, 0, 4.
  initial begin
    for (int i = 0; i < 20 && rst; i++) @(negedge clk);
    chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_addr1", w_addr, 32'h0000_0000);
    chk("wrap_pc1", w_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_addr2", w_addr, 32'h0000_0004);
  end

  initial begin
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    run(3, 1'b0);
    run(3, 1'b1);
    run(3, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'h0000_0101);
    run(3, 1'b0);
    run(2, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 32'h0000_0200);
    run(1, 1'b1);
    run(3, 1'b0);
    run(2, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    run(4, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 9) == 0, $urandom);
    end
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
